// File: rtl/pushbutton_word_entry.sv
// pushbutton_word_entry: assembles an N-bit word, MSB first, from debounced
// "0" and "1" push-buttons, and hands it to a consumer via valid/ack.
//
// Parameters:
//   N               word width (>= 2)
//   DEBOUNCE_CYCLES stable cycles required before a button level is accepted (>= 2)
//   ROLLING         0: fill-and-hold, bits arriving while full are ignored
//                   1: rolling, bits arriving while full shift in, oldest bit dropped
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   btn_zero/btn_one  asynchronous buttons entering a 0 / a 1
//   btn_clear         asynchronous button discarding the partial word
//   btn_undo          asynchronous button removing the last bit
//                     (only when PUSHBUTTON_WORD_ENTRY_UNDO_EN is defined)
//   word_ack          single-cycle consumer acknowledge
//   word_out          assembled word (registered)
//   bit_count         number of valid bits, 0..N (registered)
//   word_valid        high while the word is full
//   conflict          one-cycle pulse when zero and one presses coincide
//
// Optional feature macro: PUSHBUTTON_WORD_ENTRY_UNDO_EN
module pushbutton_word_entry #(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ROLLING         = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_zero,
  input  logic                     btn_one,
  input  logic                     btn_clear,
`ifdef PUSHBUTTON_WORD_ENTRY_UNDO_EN
  input  logic                     btn_undo,
`endif
  input  logic                     word_ack,
  output logic [N-1:0]             word_out,
  output logic [$clog2(N+1)-1:0]   bit_count,
  output logic                     word_valid,
  output logic                     conflict
);

  localparam int unsigned CNT_W     = $clog2(N + 1);
  localparam int unsigned DBC_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned BTN_ZERO  = 0;
  localparam int unsigned BTN_ONE   = 1;
  localparam int unsigned BTN_CLEAR = 2;
`ifdef PUSHBUTTON_WORD_ENTRY_UNDO_EN
  localparam int unsigned BTN_UNDO  = 3;
  localparam int unsigned NB        = 4;
`else
  localparam int unsigned NB        = 3;
`endif

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } state_e;

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    s1_q, s2_q;
  logic [NB-1:0]    lvl_q, lvl_d;
  logic [NB-1:0]    lvl_dly_q;
  logic [NB-1:0]    pulse_q;
  logic [DBC_W-1:0] dbc_q [NB];
  logic [DBC_W-1:0] dbc_d [NB];

  state_e           state_q, state_d;
  logic [N-1:0]     word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conflict_q, conflict_d;

  logic             zero_p, one_p, clear_p;

`ifdef PUSHBUTTON_WORD_ENTRY_UNDO_EN
  logic             undo_p;
  assign btn_raw = {btn_undo, btn_clear, btn_one, btn_zero};
  assign undo_p  = pulse_q[BTN_UNDO];
`else
  assign btn_raw = {btn_clear, btn_one, btn_zero};
`endif

  assign zero_p  = pulse_q[BTN_ZERO];
  assign one_p   = pulse_q[BTN_ONE];
  assign clear_p = pulse_q[BTN_CLEAR];

  // Debounce: a differing level must persist DEBOUNCE_CYCLES compares to be accepted
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < int'(NB); i++) begin
      dbc_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (dbc_q[i] == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d[i] = s2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + DBC_W'(1);
        end
      end
    end
  end

  // Button front end: synchroniser, debounce state, registered rising-edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < int'(NB); i++) begin
        dbc_q[i] <= '0;
      end
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      pulse_q   <= lvl_q & ~lvl_dly_q;
      for (int i = 0; i < int'(NB); i++) begin
        dbc_q[i] <= dbc_d[i];
      end
    end
  end

  // Word FSM: one action per cycle, clear > ack > (undo) > conflict > bit
  always_comb begin
    word_d     = word_q;
    cnt_d      = cnt_q;
    conflict_d = 1'b0;
    if (clear_p) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (word_ack && (state_q == FULL)) begin
      // A bit arriving with the ack starts the next word
      if (zero_p ^ one_p) begin
        word_d = N'(one_p);
        cnt_d  = CNT_W'(1);
      end else begin
        word_d = '0;
        cnt_d  = '0;
      end
`ifdef PUSHBUTTON_WORD_ENTRY_UNDO_EN
    end else if (undo_p) begin
      if (cnt_q != '0) begin
        word_d = word_q >> 1;
        cnt_d  = cnt_q - CNT_W'(1);
      end
      conflict_d = zero_p | one_p;
`endif
    end else if (zero_p && one_p) begin
      conflict_d = 1'b1;
    end else if (zero_p || one_p) begin
      if (cnt_q != CNT_W'(N)) begin
        word_d = {word_q[N-2:0], one_p};
        cnt_d  = cnt_q + CNT_W'(1);
      end else if (ROLLING != 0) begin
        word_d = {word_q[N-2:0], one_p};
      end
    end
    state_d = (cnt_d == CNT_W'(N)) ? FULL : FILLING;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILLING;
      word_q     <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
    end
  end

  assign word_out   = word_q;
  assign bit_count  = cnt_q;
  assign word_valid = (state_q == FULL);
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_pushbutton_word_entry.sv
// Bench for pushbutton_word_entry: a fill-and-hold and a rolling instance
// share all inputs; a reference model pushes expected outputs per press.
module tb_pushbutton_word_entry;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;
  localparam logic [3:0] S_NONE  = 4'b0000;
  localparam logic [3:0] S_ZERO  = 4'b0001;
  localparam logic [3:0] S_ONE   = 4'b0010;
  localparam logic [3:0] S_CLEAR = 4'b0100;
  localparam logic [3:0] S_UNDO  = 4'b1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_zero = 1'b0, btn_one = 1'b0, btn_clear = 1'b0, word_ack = 1'b0;
`ifdef PUSHBUTTON_WORD_ENTRY_UNDO_EN
  logic btn_undo = 1'b0;
`endif

  logic [N-1:0] wo_f, wo_r;
  logic [2:0]   bc_f, bc_r;
  logic         wv_f, wv_r, cf_f, cf_r;
  logic [17:0]  obs;

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_wf = '0, m_wr = '0;
  logic [2:0]  m_cf = '0, m_cr = '0;
  logic [17:0] sb [$];

  always #5 clk = ~clk;

  pushbutton_word_entry #(.N(N), .DEBOUNCE_CYCLES(D), .ROLLING(0)) u_fill (
    .clk(clk), .reset(reset), .btn_zero(btn_zero), .btn_one(btn_one), .btn_clear(btn_clear),
`ifdef PUSHBUTTON_WORD_ENTRY_UNDO_EN
    .btn_undo(btn_undo),
`endif
    .word_ack(word_ack), .word_out(wo_f), .bit_count(bc_f), .word_valid(wv_f), .conflict(cf_f)
  );

  pushbutton_word_entry #(.N(N), .DEBOUNCE_CYCLES(D), .ROLLING(1)) u_roll (
    .clk(clk), .reset(reset), .btn_zero(btn_zero), .btn_one(btn_one), .btn_clear(btn_clear),
`ifdef PUSHBUTTON_WORD_ENTRY_UNDO_EN
    .btn_undo(btn_undo),
`endif
    .word_ack(word_ack), .word_out(wo_r), .bit_count(bc_r), .word_valid(wv_r), .conflict(cf_r)
  );

  assign obs = {wo_f, bc_f, wv_f, cf_f, wo_r, bc_r, wv_r, cf_r};

  function automatic logic [17:0] mk(input logic [3:0] wf, input logic [2:0] cf, input logic kf,
                                     input logic [3:0] wr, input logic [2:0] cr, input logic kr);
    return {wf, cf, (cf == 3'd4), kf, wr, cr, (cr == 3'd4), kr};
  endfunction

  function automatic logic [17:0] idle_exp();
    return mk(m_wf, m_cf, 1'b0, m_wr, m_cr, 1'b0);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] sel);
    btn_zero  = sel[0];
    btn_one   = sel[1];
    btn_clear = sel[2];
`ifdef PUSHBUTTON_WORD_ENTRY_UNDO_EN
    btn_undo  = sel[3];
`endif
  endtask

  // Reference behaviour of one instance for one cycle of press pulses
  task automatic model_step(input logic [3:0] w, input logic [2:0] c, input logic [3:0] sel,
                            input bit ack, input bit roll,
                            output logic [3:0] wn, output logic [2:0] cn, output logic cfl);
    logic z, o, cl, u;
    {u, cl, o, z} = sel;
    wn = w; cn = c; cfl = 1'b0;
    if (cl) begin
      wn = '0; cn = '0;
    end else if (ack && c == 3'd4) begin
      if (z ^ o) begin wn = {3'b000, o}; cn = 3'd1; end
      else begin wn = '0; cn = '0; end
    end else if (u) begin
      if (c != 3'd0) begin wn = w >> 1; cn = c - 3'd1; end
      cfl = z | o;
    end else if (z && o) begin
      cfl = 1'b1;
    end else if (z || o) begin
      if (c < 3'd4) begin wn = {w[2:0], o}; cn = c + 3'd1; end
      else if (roll) wn = {w[2:0], o};
    end
  endtask

  task automatic sb_push(input logic [3:0] sel, input bit ack);
    logic [3:0] wf, wr;
    logic [2:0] cf, cr;
    logic kf, kr;
    model_step(m_wf, m_cf, sel, ack, 1'b0, wf, cf, kf);
    model_step(m_wr, m_cr, sel, ack, 1'b1, wr, cr, kr);
    m_wf = wf; m_cf = cf; m_wr = wr; m_cr = cr;
    sb.push_back(mk(wf, cf, kf, wr, cr, kr));
  endtask

  // Press buttons; returns 1ns after the edge where the word register updates
  task automatic do_press(input logic [3:0] sel, input bit ack);
    set_btns(sel);
    sb_push(sel, ack);
    tick(D + 3);
    word_ack = ack;
    tick(1);
    word_ack = 1'b0;
  endtask

  task automatic release_btns();
    set_btns(S_NONE);
    tick(D + 8);
  endtask

  task automatic test_reset();
    logic [17:0] got;
    tick(3);
    got = obs; checks++;
    if (got !== 18'h0) begin errors++; $display("FAIL reset_held: got %h required %h", got, 18'h0); end
    reset = 1'b0;
    tick(2);
    got = obs; checks++;
    if (got !== 18'h0) begin errors++; $display("FAIL reset_released: got %h required %h", got, 18'h0); end
  endtask

  task automatic test_fill();
    logic [3:0] seq [5];
    logic [17:0] got, exp, pre;
    seq = '{S_ONE, S_ZERO, S_ONE, S_ONE, S_ZERO};
    for (int i = 0; i < 5; i++) begin
      pre = idle_exp();
      set_btns(seq[i]);
      sb_push(seq[i], 1'b0);
      tick(D + 3);
      got = obs; checks++;
      if (got !== pre) begin errors++; $display("FAIL fill_early%0d: got %h required %h", i, got, pre); end
      tick(1);
      got = obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL fill_press%0d: got %h required %h", i, got, exp); end
      release_btns();
      got = obs; exp = idle_exp(); checks++;
      if (got !== exp) begin errors++; $display("FAIL fill_release%0d: got %h required %h", i, got, exp); end
    end
  endtask

  task automatic test_clear();
    logic [17:0] got, exp;
    do_press(S_CLEAR, 1'b0);
    got = obs; exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL clear: got %h required %h", got, exp); end
    release_btns();
  endtask

  task automatic test_bounce();
    logic [17:0] got, exp, pre;
    test_clear();
    pre = idle_exp();
    for (int i = 0; i < 3; i++) begin
      btn_one = 1'b1; tick(2);
      btn_one = 1'b0; tick(2);
    end
    got = obs; checks++;
    if (got !== pre) begin errors++; $display("FAIL bounce_glitch: got %h required %h", got, pre); end
    set_btns(S_ONE);
    sb_push(S_ONE, 1'b0);
    tick(D + 3);
    got = obs; checks++;
    if (got !== pre) begin errors++; $display("FAIL bounce_early: got %h required %h", got, pre); end
    tick(1);
    got = obs; exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bounce_entry: got %h required %h", got, exp); end
    tick(10);
    release_btns();
    got = obs; checks++;
    if (got !== exp) begin errors++; $display("FAIL bounce_single: got %h required %h", got, exp); end
  endtask

  task automatic test_rolling();
    logic [3:0] seq [5];
    logic [17:0] got, exp;
    seq = '{S_ONE, S_ONE, S_ZERO, S_ZERO, S_ONE};
    test_clear();
    for (int i = 0; i < 5; i++) begin
      do_press(seq[i], 1'b0);
      got = obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL roll_press%0d: got %h required %h", i, got, exp); end
      release_btns();
    end
    exp = mk(4'b1100, 3'd4, 1'b0, 4'b1001, 3'd4, 1'b0); checks++;
    if (obs !== exp) begin errors++; $display("FAIL roll_final: got %h required %h", obs, exp); end
  endtask

  task automatic test_ack_bit();
    logic [3:0] seq [4];
    logic [17:0] got, exp;
    seq = '{S_ONE, S_ZERO, S_ONE, S_ONE};
    test_clear();
    for (int i = 0; i < 4; i++) begin
      do_press(seq[i], 1'b0);
      void'(sb.pop_front());
      release_btns();
    end
    exp = mk(4'b1011, 3'd4, 1'b0, 4'b1011, 3'd4, 1'b0); checks++;
    if (obs !== exp) begin errors++; $display("FAIL ack_full: got %h required %h", obs, exp); end
    do_press(S_ONE, 1'b1);
    got = obs; exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL ack_with_bit: got %h required %h", got, exp); end
    release_btns();
  endtask

  task automatic test_conflict();
    logic [17:0] got, exp;
    do_press(S_ZERO | S_ONE, 1'b0);
    got = obs; exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL conflict_pulse: got %h required %h", got, exp); end
    tick(1);
    got = obs; exp = idle_exp(); checks++;
    if (got !== exp) begin errors++; $display("FAIL conflict_width: got %h required %h", got, exp); end
    release_btns();
    do_press(S_ZERO, 1'b0);
    got = obs; exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL two_bits: got %h required %h", got, exp); end
    release_btns();
    word_ack = 1'b1; tick(1); word_ack = 1'b0; tick(1);
    got = obs; exp = idle_exp(); checks++;
    if (got !== exp) begin errors++; $display("FAIL ack_not_valid: got %h required %h", got, exp); end
    test_clear();
  endtask

  task automatic test_undo();
`ifdef PUSHBUTTON_WORD_ENTRY_UNDO_EN
    logic [3:0] seq [3];
    logic [17:0] got, exp;
    seq = '{S_ONE, S_ONE, S_ZERO};
    test_clear();
    for (int i = 0; i < 3; i++) begin
      do_press(seq[i], 1'b0);
      void'(sb.pop_front());
      release_btns();
    end
    do_press(S_UNDO, 1'b0);
    got = obs; exp = mk(4'b0011, 3'd2, 1'b0, 4'b0011, 3'd2, 1'b0); checks++;
    if (got !== exp || sb.pop_front() !== exp) begin
      errors++; $display("FAIL undo: got %h required %h", got, exp);
    end
    release_btns();
`endif
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq [3];
    logic [17:0] got, exp;
    seq = '{S_ONE, S_ONE, S_ZERO};
    test_clear();
    for (int i = 0; i < 3; i++) begin
      do_press(seq[i], 1'b0);
      void'(sb.pop_front());
      release_btns();
    end
    exp = mk(4'b0110, 3'd3, 1'b0, 4'b0110, 3'd3, 1'b0); checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_word: got %h required %h", obs, exp); end
    btn_one = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    btn_one = 1'b0;
    tick(3);
    reset = 1'b0;
    m_wf = '0; m_cf = '0; m_wr = '0; m_cr = '0;
    sb.delete();
    got = obs; checks++;
    if (got !== 18'h0) begin errors++; $display("FAIL mid_reset: got %h required %h", got, 18'h0); end
    tick(D + 8);
    got = obs; checks++;
    if (got !== 18'h0) begin errors++; $display("FAIL no_stale_pulse: got %h required %h", got, 18'h0); end
    do_press(S_ONE, 1'b0);
    got = obs; exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL repress: got %h required %h", got, exp); end
    release_btns();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_clear();
    test_bounce();
    test_rolling();
    test_ack_bit();
    test_conflict();
    test_undo();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pushbutton_word_entry.md
Name: pushbutton_word_entry

Overview:
Parametrised successor to the nibble-entry block. Collects an N-bit word from two push-buttons ("0" and "1"), MSB first, with the last bit entered as the LSB. Each button has its own synchroniser, debouncer and edge detector. The block supports two modes, fill-and-hold and rolling, and reports the completed word to a downstream consumer through a valid/ack handshake.

Parameters:
- N, 4: word width in bits; N >= 2.
- DEBOUNCE_CYCLES, 16: number of consecutive stable cycles required before a button level is accepted; >= 2.
- ROLLING, 0: mode select.
  - 0: fill-and-hold; bits arriving while full are ignored.
  - 1: rolling; bits arriving while full shift in and the oldest bit is discarded.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- btn_zero  input  1  asynchronous button; enters a 0
- btn_one  input  1  asynchronous button; enters a 1
- btn_clear  input  1  asynchronous button; discards the partial word (synchronised and debounced like the others)
- word_ack  input  1  consumer acknowledge; synchronous, single-cycle
- word_out  output  N  assembled word
- bit_count  output  $clog2(N+1)  number of valid bits, 0..N
- word_valid  output  1  high while bit_count == N
- conflict  output  1  one-cycle pulse when btn_zero and btn_one press pulses coincide

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high.
  - word_out = 0, bit_count = 0, word_valid = 0, conflict = 0.
  - Every synchroniser flop, debounced level and debounce counter clears to 0.
- Per-button front end, for btn_zero, btn_one and btn_clear:
  - Two-flop synchroniser s1 -> s2.
  - Debounce counter: when s2 equals the debounced level, the counter resets to 0. When they differ, it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while s2 still differs, the debounced level takes s2 and the counter resets.
  - Press pulse = registered rising edge of the debounced level; exactly one cycle wide.
- Latency: an input held stable from clock edge k gives a register update on edge k+DEBOUNCE_CYCLES+3. Release produces no pulse. Bounces shorter than DEBOUNCE_CYCLES are invisible.
- Datapath, one action per cycle, priority highest first:
  1. Clear pulse: word_out = 0, bit_count = 0.
  2. word_ack while word_valid: the word is consumed. If a bit pulse arrives in the same cycle, word_out = {0..., bit}, bit_count = 1. Otherwise word_out = 0, bit_count = 0.
  3. Zero and one pulses in the same cycle: no change; conflict pulses for one cycle.
  4. Single bit pulse with bit_count < N: word_out = {word_out[N-2:0], bit}, bit_count + 1.
  5. Single bit pulse with bit_count == N:
     - ROLLING=1: shift as in 4; bit_count stays N.
     - ROLLING=0: ignored.
- word_ack while word_valid = 0 is ignored.
- word_valid is combinational from bit_count == N. It stays high until ack or clear; the word is held stable meanwhile (ROLLING=0).
- States:
  - FILLING: bit_count < N.
  - FULL: bit_count == N.
  - FULL -> FILLING on ack or clear.
- bit_count never exceeds N and never wraps.
- Reset mid-debounce discards the pending press. A button still held after reset is released produces a pulse only after a fresh debounce of the 1 level.

Optional Feature:
- Macro: PUSHBUTTON_WORD_ENTRY_UNDO_EN.
- Defined:
  - Adds input btn_undo, with the same synchroniser, debouncer and edge detector.
  - Undo pulse with bit_count > 0: word_out = word_out >> 1 (zero filled), bit_count - 1. Ignored when bit_count == 0.
  - Priority: below clear and ack, above bit pulses. A coincident bit pulse is dropped and conflict pulses.
  - An undo while FULL returns the block to FILLING and deasserts word_valid.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- N=4, D=4, ROLLING=0. Press 1,0,1,1 (each held 10 cycles, released 10) -> word_out 4'b1011, bit_count 4, word_valid=1. A 5th press of 0 -> unchanged.
- Same setup. btn_one bounces with 2-cycle glitches, then holds high 10 cycles -> exactly one bit entered. Update lands D+3 edges after the stable start.
- ROLLING=1. Press 1,1,0,0,1 -> word_out 4'b1001, bit_count 4, word_valid stays 1.
- Full word 4'b1011. word_ack in the same cycle as a "1" pulse -> word_out 4'b0001, bit_count 1, word_valid=0.
- Both buttons pressed within the same cycle -> conflict high for 1 cycle, word unchanged. btn_clear after 2 bits -> word_out 0, bit_count 0.
- Reset asserted mid-word (bit_count 3) and during a held button -> all outputs 0. No pulse until the button is released and pressed again; with UNDO_EN, undo on 4'b0110 (count 3) -> 4'b0011, count 2.
